// File: rtl/instr_issue_unit.sv
// rtl/instr_issue_unit.sv - fetch/issue front end; IFETCH_PREFETCH_EN adds a 1-entry prefetch buffer
module instr_issue_unit #(
    parameter int              ADDR_W   = 8,
    parameter int              INSTR_W  = 16,
    parameter int              PC_STEP  = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]      NOP_OP   = 4'b1111
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req,
    output logic [ADDR_W-1:0]    imem_addr,
    input  logic                 imem_valid,
    input  logic [INSTR_W-1:0]   imem_rdata,
    input  logic                 stall_i,
    input  logic                 redirect_i,
    input  logic [ADDR_W-1:0]    redirect_pc_i,
    output logic [3:0]           operation_o,
    output logic                 imm_o,
    output logic [INSTR_W-6:0]   payload_o,
    output logic [ADDR_W-1:0]    pc_o,
    output logic                 issue_valid_o
);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_ISSUE} state_t;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    state_t              state;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   pcNext;
    logic                drop;
    logic                pfReq;
    logic                pfBusy;
    logic [INSTR_W-1:0]  issueWord;
    logic                accept;
    logic                respPending;
    logic                stillOutstanding;

`ifdef IFETCH_PREFETCH_EN
    logic                bufValid;
    logic [INSTR_W-1:0]  bufWord;

    assign pfReq     = (state == S_ISSUE) && !bufValid && !pfBusy;
    assign issueWord = bufValid ? bufWord : imem_rdata;
`else
    assign pfReq     = 1'b0;
    assign pfBusy    = 1'b0;
    assign issueWord = imem_rdata;
`endif

    assign pcNext    = pc + STEP;
    assign imem_req  = !rst && ((state == S_FETCH) || pfReq);
    assign imem_addr = (state == S_ISSUE) ? pcNext : pc;
    assign accept    = (state == S_ISSUE) && issue_valid_o && !stall_i;

    // A request leaving this cycle, or one still unanswered, must be dropped on redirect.
    assign respPending      = (state == S_WAIT) || pfBusy;
    assign stillOutstanding = imem_req || (respPending && !imem_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_FETCH;
            pc            <= RESET_PC;
            drop          <= 1'b0;
            operation_o   <= NOP_OP;
            imm_o         <= 1'b0;
            payload_o     <= '0;
            pc_o          <= '0;
            issue_valid_o <= 1'b0;
`ifdef IFETCH_PREFETCH_EN
            bufValid      <= 1'b0;
            bufWord       <= '0;
            pfBusy        <= 1'b0;
`endif
        end else if (redirect_i) begin
            pc            <= redirect_pc_i;
            state         <= stillOutstanding ? S_WAIT : S_FETCH;
            drop          <= stillOutstanding;
            operation_o   <= NOP_OP;
            imm_o         <= 1'b0;
            issue_valid_o <= 1'b0;
`ifdef IFETCH_PREFETCH_EN
            bufValid      <= 1'b0;
            pfBusy        <= 1'b0;
`endif
        end else begin
            case (state)
                S_FETCH: state <= S_WAIT;
                S_WAIT: begin
                    if (imem_valid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= S_FETCH;
                        end else begin
                            operation_o   <= issueWord[INSTR_W-1 -: 4];
                            imm_o         <= issueWord[INSTR_W-5];
                            payload_o     <= issueWord[INSTR_W-6:0];
                            pc_o          <= pc;
                            issue_valid_o <= 1'b1;
                            state         <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
`ifdef IFETCH_PREFETCH_EN
                    if (accept) begin
                        pc     <= pcNext;
                        pfBusy <= 1'b0;
                        if (bufValid || (pfBusy && imem_valid)) begin
                            operation_o <= issueWord[INSTR_W-1 -: 4];
                            imm_o       <= issueWord[INSTR_W-5];
                            payload_o   <= issueWord[INSTR_W-6:0];
                            pc_o        <= pcNext;
                            bufValid    <= 1'b0;
                        end else begin
                            // Prefetch of pcNext is in flight (or leaving now): it becomes the main fetch.
                            operation_o   <= NOP_OP;
                            imm_o         <= 1'b0;
                            issue_valid_o <= 1'b0;
                            state         <= S_WAIT;
                        end
                    end else if (pfBusy && imem_valid) begin
                        bufValid <= 1'b1;
                        bufWord  <= imem_rdata;
                        pfBusy   <= 1'b0;
                    end else if (pfReq) begin
                        pfBusy <= 1'b1;
                    end
`else
                    if (accept) begin
                        pc            <= pcNext;
                        operation_o   <= NOP_OP;
                        imm_o         <= 1'b0;
                        issue_valid_o <= 1'b0;
                        state         <= S_FETCH;
                    end
`endif
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_issue_unit.sv
// tb/tb_instr_issue_unit.sv - directed self-checking bench for instr_issue_unit
module tb_instr_issue_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid;
    logic [15:0] imem_rdata;
    logic        stall_i;
    logic        redirect_i;
    logic [7:0]  redirect_pc_i;
    logic [3:0]  operation_o;
    logic        imm_o;
    logic [10:0] payload_o;
    logic [7:0]  pc_o;
    logic        issue_valid_o;

    logic        imemReq2;
    logic [7:0]  imemAddr2;
    logic        imemValid2;
    logic [15:0] imemRdata2;
    logic        stall2;
    logic        redirect2;
    logic [7:0]  redirectPc2;
    logic [3:0]  operation2;
    logic        imm2;
    logic [10:0] payload2;
    logic [7:0]  pc2;
    logic        issueValid2;

    int          nChecks = 0;
    int          nErrors = 0;
    int          memLat  = 1;
    int          waited;
    int          holdBad;
    logic [15:0] mem [0:255];

    instr_issue_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .operation_o(operation_o), .imm_o(imm_o), .payload_o(payload_o),
        .pc_o(pc_o), .issue_valid_o(issue_valid_o)
    );

    instr_issue_unit #(.RESET_PC(8'hFF)) dutWrap (
        .clk(clk), .rst(rst),
        .imem_req(imemReq2), .imem_addr(imemAddr2),
        .imem_valid(imemValid2), .imem_rdata(imemRdata2),
        .stall_i(stall2), .redirect_i(redirect2), .redirect_pc_i(redirectPc2),
        .operation_o(operation2), .imm_o(imm2), .payload_o(payload2),
        .pc_o(pc2), .issue_valid_o(issueValid2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic waitIssue(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!issue_valid_o && n < 20);
        checkEq("issue_arrives", issue_valid_o, 1);
    endtask

    task automatic waitReq();
        for (int k = 0; k < 20 && !imem_req; k++) @(negedge clk);
        checkEq("req_arrives", imem_req, 1);
    endtask

    // Instruction memory: answers each request memLat cycles later, sampled after the negedge.
    initial begin
        logic       pending;
        int         cnt;
        logic [7:0] pendAddr;
        pending    = 1'b0;
        cnt        = 0;
        pendAddr   = '0;
        imem_valid = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            imem_valid = 1'b0;
            if (pending) begin
                if (cnt <= 1) begin
                    imem_valid = 1'b1;
                    imem_rdata = mem[pendAddr];
                    pending    = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (imem_req) begin
                pending  = 1'b1;
                cnt      = memLat;
                pendAddr = imem_addr;
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hE000 + 16'(i);
        mem[0]    = 16'h0123;
        mem[1]    = 16'h1ABC;
        mem[2]    = 16'h5C21;
        mem[3]    = 16'h2222;
        mem[8'h40] = 16'h7044;

        rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        stall2 = 1'b0; redirect2 = 1'b0; redirectPc2 = '0; imemValid2 = 1'b0; imemRdata2 = '0;
`ifdef IFETCH_PREFETCH_EN
        stall_i = 1'b1;
`endif
        repeat (3) @(negedge clk);
        checkEq("rst_req", imem_req, 0);
        checkEq("rst_op", operation_o, 4'hF);
        checkEq("rst_imm", imm_o, 0);
        checkEq("rst_payload", payload_o, 0);
        checkEq("rst_pc_o", pc_o, 0);
        checkEq("rst_valid", issue_valid_o, 0);
        rst = 1'b0;
        #2;
        checkEq("first_req", imem_req, 1);
        checkEq("first_addr", imem_addr, 8'h00);
        checkEq("wrap_first_req", imemReq2, 1);
        checkEq("wrap_first_addr", imemAddr2, 8'hFF);

`ifndef IFETCH_PREFETCH_EN
        waitIssue(waited);
        checkEq("i0_op", operation_o, 4'h0);
        checkEq("i0_imm", imm_o, 0);
        checkEq("i0_payload", payload_o, 11'h123);
        checkEq("i0_pc", pc_o, 8'h00);
        waitIssue(waited);
        checkEq("issue_period", waited, 3);
        checkEq("i1_op", operation_o, 4'h1);
        checkEq("i1_imm", imm_o, 1);
        checkEq("i1_payload", payload_o, 11'h2BC);
        checkEq("i1_pc", pc_o, 8'h01);

        @(negedge clk);
        stall_i = 1'b1;
        waitIssue(waited);
        checkEq("i2_op", operation_o, 4'h5);
        checkEq("i2_imm", imm_o, 1);
        checkEq("i2_payload", payload_o, 11'h421);
        holdBad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (operation_o !== 4'h5 || imm_o !== 1'b1 || payload_o !== 11'h421 ||
                pc_o !== 8'h02 || issue_valid_o !== 1'b1 || imem_req !== 1'b0)
                holdBad++;
        end
        checkEq("stall_hold_changes", holdBad, 0);
        stall_i = 1'b0;
        memLat  = 3;
        @(negedge clk);
        checkEq("release_valid", issue_valid_o, 0);
        checkEq("release_op", operation_o, 4'hF);
        checkEq("release_imm", imm_o, 0);
        checkEq("release_req", imem_req, 1);
        checkEq("release_addr", imem_addr, 8'h03);

        @(negedge clk);
        redirect_i = 1'b1; redirect_pc_i = 8'h40;
        @(negedge clk);
        redirect_i = 1'b0;
        memLat = 1;
        checkEq("redir_valid", issue_valid_o, 0);
        checkEq("redir_no_req", imem_req, 0);
        waitReq();
        checkEq("redir_addr", imem_addr, 8'h40);
        waitIssue(waited);
        checkEq("redir_pc", pc_o, 8'h40);
        checkEq("redir_op", operation_o, 4'h7);
`else
        repeat (4) @(negedge clk);
        checkEq("pf_held_pc", pc_o, 8'h00);
        checkEq("pf_held_op", operation_o, 4'h0);
        checkEq("pf_held_valid", issue_valid_o, 1);
        checkEq("pf_buf_full_noreq", imem_req, 0);
        stall_i = 1'b0;
        @(negedge clk);
        checkEq("pf_b2b_valid", issue_valid_o, 1);
        checkEq("pf_b2b_pc", pc_o, 8'h01);
        checkEq("pf_b2b_op", operation_o, 4'h1);
        checkEq("pf_next_req", imem_req, 1);
        checkEq("pf_next_addr", imem_addr, 8'h02);
        stall_i = 1'b1;
        repeat (2) @(negedge clk);
        checkEq("pf_hold2_pc", pc_o, 8'h01);
        checkEq("pf_hold2_noreq", imem_req, 0);
        redirect_i = 1'b1; redirect_pc_i = 8'h40;
        @(negedge clk);
        redirect_i = 1'b0; stall_i = 1'b0;
        checkEq("pf_flush_valid", issue_valid_o, 0);
        checkEq("pf_flush_op", operation_o, 4'hF);
        checkEq("pf_flush_req", imem_req, 1);
        checkEq("pf_flush_addr", imem_addr, 8'h40);
        waitIssue(waited);
        checkEq("pf_redir_pc", pc_o, 8'h40);
        checkEq("pf_redir_op", operation_o, 4'h7);
`endif

        imemValid2 = 1'b1; imemRdata2 = 16'h4801;
        @(negedge clk);
        imemValid2 = 1'b0;
        checkEq("wrap_issue_valid", issueValid2, 1);
        checkEq("wrap_issue_pc", pc2, 8'hFF);
        checkEq("wrap_issue_op", operation2, 4'h4);
        for (int k = 0; k < 4 && !imemReq2; k++) @(negedge clk);
        checkEq("wrap_req", imemReq2, 1);
        checkEq("wrap_addr", imemAddr2, 8'h00);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
